// File: rtl/nfmac10g_pkg.sv
// Shared constants and FSM state type for the nfmac10g Tx AXIS arbitration path.
package nfmac10g_pkg;

    localparam int AXIS_DATA_W = 64;
    localparam int AXIS_KEEP_W = 8;
    localparam logic [AXIS_KEEP_W-1:0] KEEP_FULL = 8'hFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } tx_state_e;

    // Only the final beat of a frame may be partial, and no beat may be empty.
    function automatic logic keep_bad(input logic [AXIS_KEEP_W-1:0] keep, input logic last);
        return (!last && keep != KEEP_FULL) || (keep == '0);
    endfunction

endpackage

// File: rtl/axis_tx_arbiter_rr_arbiter.sv
// Rotating-priority encoder: first requester at or after ptr (mod NUM_PORTS), ignoring masked ports.
module rr_arbiter
    import nfmac10g_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    input  logic [NUM_PORTS-1:0] mask,
    output logic                 hit,
    output logic [IDX_W-1:0]     idx
);

    localparam logic [IDX_W:0] NP = (IDX_W+1)'(NUM_PORTS);

    logic [NUM_PORTS-1:0] avail;
    logic [NUM_PORTS-1:0] rot;
    logic [IDX_W:0]       sum;

    assign avail = req & ~mask;
    // Rotate so that bit 0 is the port at ptr; works for any NUM_PORTS since ptr < NUM_PORTS.
    assign rot   = NUM_PORTS'({avail, avail} >> ptr);

    always_comb begin
        hit = 1'b0;
        sum = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (rot[k] && !hit) begin
                hit = 1'b1;
                sum = {1'b0, ptr} + (IDX_W+1)'(k);
            end
        end
        if (sum >= NP) begin
            sum = sum - NP;
        end
        idx = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/axis_tx_arbiter.sv
// Packet-level round-robin arbiter sharing the nfmac10g Tx AXIS port among NUM_PORTS sources.
// Grant is held from first beat to tlast; per-port packet counters and a sticky tkeep error flag.
module axis_tx_arbiter
    import nfmac10g_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = 2,
    parameter int CNT_W     = 32
) (
    input  logic                               clk,
    input  logic                               tx_axis_aresetn,
    input  logic [NUM_PORTS*AXIS_DATA_W-1:0]   s_axis_tdata,
    input  logic [NUM_PORTS*AXIS_KEEP_W-1:0]   s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]               s_axis_tvalid,
    output logic [NUM_PORTS-1:0]               s_axis_tready,
    input  logic [NUM_PORTS-1:0]               s_axis_tlast,
    input  logic [NUM_PORTS-1:0]               s_axis_tuser,
    output logic [AXIS_DATA_W-1:0]             m_axis_tdata,
    output logic [AXIS_KEEP_W-1:0]             m_axis_tkeep,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic                               m_axis_tlast,
    output logic                               m_axis_tuser,
    output logic [IDX_W-1:0]                   grant_idx,
    output logic                               grant_vld,
    output logic [NUM_PORTS*CNT_W-1:0]         pkt_cnt,
    output logic                               keep_err
);

    localparam logic [IDX_W:0] NP = (IDX_W+1)'(NUM_PORTS);

    tx_state_e            state_q;
    logic [IDX_W-1:0]     gidx_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [CNT_W-1:0]     cnt_q [NUM_PORTS];
    logic                 keep_err_q;

    logic                 xfer;
    logic                 beat;
    logic [IDX_W:0]       inc;
    logic [IDX_W-1:0]     nxt_ptr;
    logic [IDX_W-1:0]     arb_ptr;
    logic [NUM_PORTS-1:0] arb_mask;
    logic                 arb_hit;
    logic [IDX_W-1:0]     arb_idx;

    assign xfer    = (state_q == ST_XFER);
    assign inc     = {1'b0, gidx_q} + (IDX_W+1)'(1);
    assign nxt_ptr = (inc == NP) ? '0 : inc[IDX_W-1:0];

    // One encoder serves both paths: IDLE searches from rr_ptr, XFER pre-searches the
    // successor of the current owner (owner masked) so a tlast beat can hand over with no bubble.
    assign arb_ptr  = xfer ? nxt_ptr : rr_ptr_q;
    assign arb_mask = xfer ? (NUM_PORTS'(1) << gidx_q) : '0;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr (
        .req  (s_axis_tvalid),
        .ptr  (arb_ptr),
        .mask (arb_mask),
        .hit  (arb_hit),
        .idx  (arb_idx)
    );

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = '0;
        if (xfer) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (gidx_q == IDX_W'(i)) begin
                    m_axis_tdata     = s_axis_tdata[AXIS_DATA_W*i +: AXIS_DATA_W];
                    m_axis_tkeep     = s_axis_tkeep[AXIS_KEEP_W*i +: AXIS_KEEP_W];
                    m_axis_tvalid    = s_axis_tvalid[i];
                    m_axis_tlast     = s_axis_tlast[i];
                    m_axis_tuser     = s_axis_tuser[i];
                    s_axis_tready[i] = m_axis_tready;
                end
            end
        end
    end

    assign beat = m_axis_tvalid & m_axis_tready;

    always_ff @(posedge clk or negedge tx_axis_aresetn) begin
        if (!tx_axis_aresetn) begin
            state_q    <= ST_IDLE;
            gidx_q     <= '0;
            rr_ptr_q   <= '0;
            keep_err_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            if (beat && keep_bad(m_axis_tkeep, m_axis_tlast)) begin
                keep_err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (arb_hit) begin
                        gidx_q  <= arb_idx;
                        state_q <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (beat && m_axis_tlast) begin
                        cnt_q[gidx_q] <= cnt_q[gidx_q] + CNT_W'(1);
                        rr_ptr_q      <= nxt_ptr;
                        if (arb_hit) begin
                            gidx_q <= arb_idx;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        pkt_cnt = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            pkt_cnt[CNT_W*i +: CNT_W] = cnt_q[i];
        end
    end

    assign grant_idx = gidx_q;
    assign grant_vld = xfer;
    assign keep_err  = keep_err_q;

endmodule
